// File: rtl/error_angle_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : error_angle_pkg
// Purpose  : Shared types and helpers for the error-angle generator.
//            This package holds the per-channel FSM state enum, the
//            saturation-limit helper and the magnitude helper.
// Revision : 1.0 - initial release
// ============================================================================
package error_angle_pkg;

  // Per-channel drive FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Largest magnitude a signed counter of the given width may hold;
  // the most negative code is never used, so the range is symmetric
  function automatic int sat_limit(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Absolute value of a (symmetric-range) counter value
  function automatic int magnitude(input int value);
    return (value < 0) ? -value : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/error_angle_chan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : error_angle_chan
// Purpose  : One error-angle channel. It keeps a saturating signed error
//            counter, latches it on each reference tick and emits a
//            registered up/down drive pulse whose length is |latched| clocks.
//            Optional sticky saturation flag: ERROR_ANGLE_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module error_angle_chan
  import error_angle_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int COARSE_STEP = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_tick,
  input  logic ec_en,
  input  logic ec_clr,
  input  logic coarse,
  input  logic inc_up,
  input  logic inc_dn,
  output logic up_lvl,
  output logic dn_lvl,
  output logic ovf
);

  localparam int LIM   = sat_limit(WIDTH);
  localparam int PWM_W = WIDTH - 1;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] latch_q, latch_d;
  logic [PWM_W-1:0]        pwm_q, pwm_d;
  logic                    up_lvl_q, up_lvl_d;
  logic                    dn_lvl_q, dn_lvl_d;

  logic apply;     // a single-direction step is actually taken this cycle
  logic hit;       // that step would cross a limit and gets clamped
  logic load;      // reference tick latches the counter and restarts the PWM
  int   step;
  int   sum;
  int   next_cnt;
  int   mag;

  // Error counter: enable/clear priority, then saturating +/- step
  always_comb begin
    step  = coarse ? COARSE_STEP : 1;
    apply = ec_en && !ec_clr && (inc_up ^ inc_dn);
    sum   = inc_up ? (int'(cnt_q) + step) : (int'(cnt_q) - step);
    hit   = apply && ((sum > LIM) || (sum < -LIM));
    if (!ec_en || ec_clr) begin
      next_cnt = 0;
    end else if (!apply) begin
      next_cnt = int'(cnt_q);
    end else if (hit) begin
      next_cnt = inc_up ? LIM : -LIM;
    end else begin
      next_cnt = sum;
    end
    cnt_d = WIDTH'(next_cnt);
  end

  // Next-state logic: dropping the enable always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!ec_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: state_d = ref_tick ? ST_DRIVE : ST_ARMED;
        ST_DRIVE: state_d = ST_DRIVE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Latch / PWM counter and the drive levels one clock ahead of the flops;
  // the latch takes the counter value after this cycle's update
  always_comb begin
    load    = ec_en && ref_tick && ((state_q == ST_ARMED) || (state_q == ST_DRIVE));
    latch_d = latch_q;
    pwm_d   = pwm_q;
    if (state_d == ST_IDLE) begin
      latch_d = '0;
      pwm_d   = '0;
    end else if (load) begin
      latch_d = cnt_d;
      pwm_d   = '0;
    end else if ((state_d == ST_DRIVE) && !(&pwm_q)) begin
      pwm_d = pwm_q + PWM_W'(1);
    end
    mag      = magnitude(int'(latch_d));
    up_lvl_d = (state_d == ST_DRIVE) && (latch_d > 0) && (int'(pwm_d) < mag);
    dn_lvl_d = (state_d == ST_DRIVE) && (latch_d < 0) && (int'(pwm_d) < mag);
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      latch_q  <= '0;
      pwm_q    <= '0;
      up_lvl_q <= 1'b0;
      dn_lvl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
      pwm_q    <= pwm_d;
      up_lvl_q <= up_lvl_d;
      dn_lvl_q <= dn_lvl_d;
    end
  end

  assign up_lvl = up_lvl_q;
  assign dn_lvl = dn_lvl_q;

`ifdef ERROR_ANGLE_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky saturation flag; a clamp in the same cycle beats a clear
  always_comb begin
    ovf_d = ovf_q;
    if (!ec_en || ec_clr) ovf_d = 1'b0;
    if (hit)              ovf_d = 1'b1;
  end

  // Saturation flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/error_angle_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : error_angle_gen
// Purpose  : Multi-channel error-angle drive generator. Each channel is an
//            independent error_angle_chan; only ref_tick is shared.
//            Optional sticky saturation flag: ERROR_ANGLE_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module error_angle_gen
  import error_angle_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int WIDTH       = 9,
  parameter int COARSE_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_tick,
  input  logic [CHANNELS-1:0] ec_en,
  input  logic [CHANNELS-1:0] ec_clr,
  input  logic [CHANNELS-1:0] coarse,
  input  logic [CHANNELS-1:0] inc_up,
  input  logic [CHANNELS-1:0] inc_dn,
  output logic [CHANNELS-1:0] up_lvl,
  output logic [CHANNELS-1:0] dn_lvl,
  output logic [CHANNELS-1:0] ovf
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    error_angle_chan #(
      .WIDTH       (WIDTH),
      .COARSE_STEP (COARSE_STEP)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .ref_tick (ref_tick),
      .ec_en    (ec_en[ch]),
      .ec_clr   (ec_clr[ch]),
      .coarse   (coarse[ch]),
      .inc_up   (inc_up[ch]),
      .inc_dn   (inc_dn[ch]),
      .up_lvl   (up_lvl[ch]),
      .dn_lvl   (dn_lvl[ch]),
      .ovf      (ovf[ch])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_error_angle_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_error_angle_gen
// Purpose  : Self-checking bench for error_angle_gen: directed scenarios with
//            hand-computed expectations, then randomized traffic compared
//            every cycle against an integer behavioural model.
//            Honours ERROR_ANGLE_OVF_EN for the expected ovf behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_error_angle_gen;

  localparam int CH  = 3;
  localparam int W   = 9;
  localparam int CS  = 8;
  localparam int LIM = 255;
`ifdef ERROR_ANGLE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          ref_tick = 1'b0;
  logic [CH-1:0] ec_en    = '0;
  logic [CH-1:0] ec_clr   = '0;
  logic [CH-1:0] coarse   = '0;
  logic [CH-1:0] inc_up   = '0;
  logic [CH-1:0] inc_dn   = '0;
  logic [CH-1:0] up_lvl, dn_lvl, ovf;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: integer counter, latched value, cycles since latch,
  // and phase (0 = off, 1 = waiting for tick, 2 = driving)
  int m_cnt [CH] = '{default: 0};
  int m_lat [CH] = '{default: 0};
  int m_age [CH] = '{default: 0};
  int m_ph  [CH] = '{default: 0};
  bit m_ovf [CH] = '{default: 1'b0};
  int m_t;

  int win_up [CH];
  int win_dn [CH];

  error_angle_gen #(.CHANNELS(CH), .WIDTH(W), .COARSE_STEP(CS)) dut (
    .clk(clk), .rst(rst), .ref_tick(ref_tick),
    .ec_en(ec_en), .ec_clr(ec_clr), .coarse(coarse),
    .inc_up(inc_up), .inc_dn(inc_dn),
    .up_lvl(up_lvl), .dn_lvl(dn_lvl), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d @%0t: got %0d, expected %0d", name, ch, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts drive-high cycles, starting with the current sample
  task automatic count_window(input int n);
    for (int i = 0; i < CH; i++) begin win_up[i] = 0; win_dn[i] = 0; end
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      for (int i = 0; i < CH; i++) begin
        if (up_lvl[i]) win_up[i]++;
        if (dn_lvl[i]) win_dn[i]++;
      end
    end
  endtask

  task automatic pulse_ref();
    ref_tick = 1'b1;
    tick();
    ref_tick = 1'b0;
  endtask

  // Model update on every active edge (or asynchronous reset)
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < CH; i++) begin
      if (rst || !ec_en[i]) begin
        m_cnt[i] = 0; m_lat[i] = 0; m_age[i] = 0; m_ph[i] = 0; m_ovf[i] = 1'b0;
      end else begin
        if (ec_clr[i]) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
        end else if (inc_up[i] != inc_dn[i]) begin
          m_t = m_cnt[i] + (inc_up[i] ? 1 : -1) * (coarse[i] ? CS : 1);
          if (m_t > LIM)       begin m_t = LIM;  m_ovf[i] = 1'b1; end
          else if (m_t < -LIM) begin m_t = -LIM; m_ovf[i] = 1'b1; end
          m_cnt[i] = m_t;
        end
        if (m_ph[i] == 0)       m_ph[i] = 1;
        else if (ref_tick)      begin m_ph[i] = 2; m_lat[i] = m_cnt[i]; m_age[i] = 0; end
        else if (m_ph[i] == 2)  m_age[i]++;
      end
    end
  end

  // Compare process: every falling edge, every channel
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < CH; i++) begin
        int mag;
        bit e_up, e_dn;
        mag  = (m_lat[i] < 0) ? -m_lat[i] : m_lat[i];
        e_up = (m_ph[i] == 2) && (m_lat[i] > 0) && (m_age[i] < mag);
        e_dn = (m_ph[i] == 2) && (m_lat[i] < 0) && (m_age[i] < mag);
        check("model_up_lvl", i, 32'(up_lvl[i]), 32'(e_up));
        check("model_dn_lvl", i, 32'(dn_lvl[i]), 32'(e_dn));
        check("model_ovf",    i, 32'(ovf[i]),    32'(OVF_ON & m_ovf[i]));
      end
    end
  end

  initial begin
    tick();
    cmp_en = 1'b1;
    tick();
    for (int i = 0; i < CH; i++) begin
      check("reset_up", i, 32'(up_lvl[i]), 0);
      check("reset_dn", i, 32'(dn_lvl[i]), 0);
      check("reset_ovf", i, 32'(ovf[i]), 0);
    end
    rst = 1'b0;
    ec_en = '1;
    tick();

    // Five fine steps up -> five-cycle up pulse starting one clock after tick
    inc_up[0] = 1'b1; repeat (5) tick(); inc_up[0] = 1'b0;
    pulse_ref();
    check("first_cycle_up", 0, 32'(up_lvl[0]), 1);
    count_window(12);
    check("pulse5_up_len", 0, win_up[0], 5);
    check("pulse5_dn_len", 0, win_dn[0], 0);

    // Three coarse steps down -> -24, 24-cycle down pulse
    coarse[1] = 1'b1; inc_dn[1] = 1'b1; repeat (3) tick(); inc_dn[1] = 1'b0; coarse[1] = 1'b0;
    pulse_ref();
    count_window(40);
    check("coarse_dn_len", 1, win_dn[1], 24);
    check("coarse_up_len", 1, win_up[1], 0);

    // Saturation: 300 up steps clamp at 255
    ec_clr = '1; tick(); ec_clr = '0;
    inc_up[0] = 1'b1; repeat (300) tick(); inc_up[0] = 1'b0;
    check("sat_ovf_set", 0, 32'(ovf[0]), 32'(OVF_ON));
    pulse_ref();
    count_window(300);
    check("sat_up_len", 0, win_up[0], 255);
    ec_clr[0] = 1'b1; tick(); ec_clr[0] = 1'b0;
    check("clr_ovf", 0, 32'(ovf[0]), 0);
    pulse_ref();
    count_window(10);
    check("clr_up_len", 0, win_up[0], 0);

    // Simultaneous up/down holds; neighbour channel independent
    ec_clr = '1; tick(); ec_clr = '0;
    inc_up[1] = 1'b1; inc_dn[1] = 1'b1; inc_up[2] = 1'b1; tick();
    inc_up = '0; inc_dn = '0;
    pulse_ref();
    count_window(5);
    check("hold_ch1", 1, win_up[1] + win_dn[1], 0);
    check("inc_ch2_up", 2, win_up[2], 1);
    check("inc_ch2_dn", 2, win_dn[2], 0);

    // Asynchronous reset in the middle of an up pulse
    ec_clr[0] = 1'b1; tick(); ec_clr[0] = 1'b0;
    inc_up[0] = 1'b1; repeat (10) tick(); inc_up[0] = 1'b0;
    pulse_ref();
    tick(); tick();
    check("pre_rst_up", 0, 32'(up_lvl[0]), 1);
    #2 rst = 1'b1;
    #1 check("async_rst_up", 0, 32'(up_lvl[0]), 0);
    tick(); tick();
    rst = 1'b0;
    inc_up[0] = 1'b1; repeat (4) tick(); inc_up[0] = 1'b0;
    count_window(20);
    check("no_tick_after_rst", 0, win_up[0], 0);
    pulse_ref();
    count_window(10);
    check("post_rst_up_len", 0, win_up[0], 4);

    // Enable dropped mid-drive: outputs low next cycle, counter zeroed
    ec_clr[0] = 1'b1; tick(); ec_clr[0] = 1'b0;
    inc_up[0] = 1'b1; repeat (20) tick(); inc_up[0] = 1'b0;
    pulse_ref();
    tick(); tick(); tick();
    ec_en[0] = 1'b0; tick();
    check("en_drop_up", 0, 32'(up_lvl[0]), 0);
    ec_en[0] = 1'b1; tick(); tick();
    pulse_ref();
    count_window(25);
    check("en_drop_cnt_zero", 0, win_up[0], 0);

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < CH; i++) begin
        ec_en[i]  = ($urandom_range(0, 31) != 0);
        ec_clr[i] = ($urandom_range(0, 47) == 0);
        coarse[i] = ($urandom_range(0, 3) == 0);
        inc_up[i] = ($urandom_range(0, 2) == 0);
        inc_dn[i] = ($urandom_range(0, 2) == 0);
      end
      ref_tick = ($urandom_range(0, 59) == 0);
      tick();
      if (c == 1200) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    ec_en = '0; ref_tick = 1'b0; inc_up = '0; inc_dn = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
